// File: rtl/ad9361_cfg_pkg.sv
// ad9361_cfg_pkg: opcodes, FSM states and ROM word layout shared by the AD9361 config sequencer.
package ad9361_cfg_pkg;
   localparam logic [2:0] OP_WRITE = 3'd0;
   localparam logic [2:0] OP_WAIT  = 3'd1;
   localparam logic [2:0] OP_PSET  = 3'd2;
   localparam logic [2:0] OP_PCLR  = 3'd3;
   localparam logic [2:0] OP_END   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_SPI,
      S_GAP,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   function automatic int word_w(input int aw, input int dw);
      return 3 + aw + dw;
   endfunction

   function automatic int op_lsb(input int aw, input int dw);
      return aw + dw;
   endfunction

   function automatic int addr_lsb(input int dw);
      return dw;
   endfunction
endpackage

// File: rtl/ad9361_cfg_seq_rom.sv
// ad9361_cfg_seq_rom: command ROM built from a packed profile image, one-cycle registered read.
// Entries beyond the image read as zero.
module ad9361_cfg_seq_rom #(
   parameter int AW = 12,
   parameter int DW = 21,
   parameter int N  = 1,
   parameter logic [N*DW-1:0] INIT = '0
) (
   input  logic          clk,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] o_data
);
   localparam int NE = N < 2**AW ? N : 2**AW;

   logic [DW-1:0] w_word;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < NE; i++) w_word = i_addr == AW'(i) ? INIT[i*DW +: DW] : w_word;
   end

   always_ff @(posedge clk) o_data <= w_word;
endmodule

// File: rtl/ad9361_cfg_seq.sv
// ad9361_cfg_seq: ROM-driven AD9361 register-configuration sequencer with timed waits,
// bit polls and a request/done SPI master handshake; re-triggerable through start.
module ad9361_cfg_seq
   import ad9361_cfg_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 8,
   parameter int ROM_AW   = 12,
   parameter int TICK_DIV = 1000,
   parameter int POLL_GAP = 64,
   parameter int POLL_MAX = 255,
   parameter int ROM_N    = 1,
   parameter logic [ROM_N*(3+ADDR_W+DATA_W)-1:0] ROM_INIT = {OP_END, {(ADDR_W+DATA_W){1'b0}}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              spi_req,
   output logic              spi_rw,
   output logic [ADDR_W-1:0] spi_addr,
   output logic [DATA_W-1:0] spi_wdata,
   input  logic              spi_done,
   input  logic [DATA_W-1:0] spi_rdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ROM_AW-1:0] err_step
);
   localparam int WW   = word_w(ADDR_W, DATA_W);
   localparam int OP_L = op_lsb(ADDR_W, DATA_W);
   localparam int AD_L = addr_lsb(DATA_W);
   localparam int TW   = ADDR_W + DATA_W + $clog2(TICK_DIV);
   localparam int GW   = $clog2(POLL_GAP + 1);
   localparam int CW   = TW > GW ? TW : GW;
   localparam int PW   = $clog2(POLL_MAX + 1);

   state_t            r_state, w_nxt;
   logic [ROM_AW-1:0] r_pc, w_pc_nxt;
   logic [CW-1:0]     r_cnt;
   logic [PW-1:0]     r_tries;
   logic [WW-1:0]     w_word;
   logic [2:0]        w_op;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              w_match, w_give_up, w_cnt_end, w_idle, w_req_nxt, w_busy_nxt;

   // ROM re-reads r_pc every cycle, so the word stays valid for the whole step.
   ad9361_cfg_seq_rom #(.AW(ROM_AW), .DW(WW), .N(ROM_N), .INIT(ROM_INIT)) u_rom (
      .clk    (clk),
      .i_addr (r_pc),
      .o_data (w_word)
   );

   assign w_op      = w_word[OP_L +: 3];
   assign w_addr    = w_word[AD_L +: ADDR_W];
   assign w_data    = w_word[DATA_W-1:0];
   assign w_match   = w_op == OP_PSET ? (spi_rdata & w_data) == w_data : (spi_rdata & w_data) == '0;
   assign w_give_up = r_tries == PW'(POLL_MAX - 1);
   assign w_cnt_end = r_cnt <= CW'(1);
   assign w_idle    = r_state inside {S_IDLE, S_DONE, S_ERR};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_cnt     <= '0;
         r_tries   <= '0;
         spi_req   <= 1'b0;
         spi_rw    <= 1'b0;
         spi_addr  <= '0;
         spi_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_step  <= '0;
      end else begin
         r_state <= w_nxt;
         r_pc    <= w_pc_nxt;
         spi_req <= w_req_nxt;
         busy    <= w_busy_nxt;
         done    <= w_nxt == S_DONE;
         error   <= w_nxt == S_ERR;
         if (w_nxt == S_ERR && r_state != S_ERR) err_step <= r_pc;
         if (r_state == S_EXEC && w_nxt == S_SPI) begin
            spi_rw    <= w_op != OP_WRITE;
            spi_addr  <= w_addr;
            spi_wdata <= w_data;
         end
         if (r_state == S_EXEC) begin
            r_cnt   <= CW'({w_addr, w_data}) * CW'(TICK_DIV);
            r_tries <= '0;
         end else if (r_state == S_SPI && spi_done) begin
            r_cnt   <= CW'(POLL_GAP);
            r_tries <= r_tries + 1'b1;
         end else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: w_nxt = start ? S_FETCH : r_state;
         S_FETCH: w_nxt = S_EXEC;
         // The last ROM entry may only be END: anything else errors instead of wrapping pc.
         S_EXEC:
            if (w_op == OP_END) w_nxt = S_DONE;
            else if (w_op > OP_END || &r_pc) w_nxt = S_ERR;
            else w_nxt = w_op == OP_WAIT ? S_WAIT : S_SPI;
         S_SPI:
            if (spi_done) w_nxt = (w_op == OP_WRITE || w_match) ? S_FETCH : w_give_up ? S_ERR : S_GAP;
         S_GAP: w_nxt = w_cnt_end ? S_SPI : S_GAP;
         S_WAIT: w_nxt = w_cnt_end ? S_FETCH : S_WAIT;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_req_nxt  = w_nxt == S_SPI && r_state != S_SPI;
      w_busy_nxt = !(w_nxt inside {S_IDLE, S_DONE, S_ERR});
      w_pc_nxt   = w_nxt != S_FETCH ? r_pc : w_idle ? '0 : r_pc + 1'b1;
   end
endmodule

// File: tb/tb_ad9361_cfg_seq.sv
// tb_ad9361_cfg_seq: five sequencer instances with different ROM profiles, driven from a
// case table; a responder answers each spi_req LAT cycles later from a queue of expected requests.
module tb_ad9361_cfg_seq;
   localparam int NI  = 5;
   localparam int LAT = 7;

   function automatic logic [20:0] wd(input logic [2:0] op, input logic [9:0] a, input logic [7:0] d);
      return {op, a, d};
   endfunction

   localparam logic [20:0] NOP = 21'd0;
   localparam logic [20:0] EOP = {3'd4, 18'd0};
   localparam int AWS [NI] = '{12, 12, 12, 12, 2};
   localparam int PMS [NI] = '{255, 255, 3, 255, 255};
   localparam logic [83:0] IMG [NI] = '{
      {NOP, NOP, EOP, wd(3'd0, 10'h3F5, 8'h01)},
      {NOP, NOP, EOP, wd(3'd1, 10'h000, 8'h03)},
      {NOP, NOP, EOP, wd(3'd2, 10'h247, 8'h02)},
      {EOP, wd(3'd7, 10'h000, 8'h00), wd(3'd0, 10'h011, 8'hBB), wd(3'd0, 10'h010, 8'hAA)},
      {wd(3'd0, 10'h3FF, 8'hFF), wd(3'd3, 10'h120, 8'h80), wd(3'd1, 10'h000, 8'h00), wd(3'd0, 10'h100, 8'h55)}
   };

   typedef struct {
      logic       rw;
      logic [9:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int         cyc;
   } tx_t;

   typedef struct {
      int          k;
      int          tx0;
      int          ntx;
      bit          dn0;
      int          sp_start;
      int          sp_done;
      logic        e_done;
      logic        e_err;
      logic [11:0] e_step;
      int          e_end;
   } tc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a    [NI];
   logic        spi_done_a [NI];
   logic [7:0]  rdata_a    [NI];
   logic        req_a      [NI];
   logic        rw_a       [NI];
   logic [9:0]  addr_a     [NI];
   logic [7:0]  wdata_a    [NI];
   logic        busy_a     [NI];
   logic        done_a     [NI];
   logic        error_a    [NI];
   logic [11:0] step_a     [NI];

   tx_t txs [11];
   tc_t tcs [8];
   tx_t sb [$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int AW = AWS[g];
      logic [AW-1:0] es;
      ad9361_cfg_seq #(
         .ADDR_W(10), .DATA_W(8), .ROM_AW(AW), .TICK_DIV(4), .POLL_GAP(8),
         .POLL_MAX(PMS[g]), .ROM_N(4), .ROM_INIT(IMG[g])
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_a[g]),
         .spi_req   (req_a[g]),
         .spi_rw    (rw_a[g]),
         .spi_addr  (addr_a[g]),
         .spi_wdata (wdata_a[g]),
         .spi_done  (spi_done_a[g]),
         .spi_rdata (rdata_a[g]),
         .busy      (busy_a[g]),
         .done      (done_a[g]),
         .error     (error_a[g]),
         .err_step  (es)
      );
      assign step_a[g] = 12'(es);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input int k, input string tag);
      chk($sformatf("%s_req%0d", tag, k), req_a[k], 0);
      chk($sformatf("%s_rw%0d", tag, k), rw_a[k], 0);
      chk($sformatf("%s_addr%0d", tag, k), addr_a[k], 0);
      chk($sformatf("%s_wdata%0d", tag, k), wdata_a[k], 0);
      chk($sformatf("%s_busy%0d", tag, k), busy_a[k], 0);
      chk($sformatf("%s_done%0d", tag, k), done_a[k], 0);
      chk($sformatf("%s_err%0d", tag, k), error_a[k], 0);
      chk($sformatf("%s_step%0d", tag, k), step_a[k], 0);
   endtask

   // Cycle c is observed at the negedge inside it; inputs set there are sampled at its closing edge.
   task automatic run(input tc_t t);
      int  due;
      int  fin;
      tx_t cur;
      cur = txs[0];
      for (int i = 0; i < t.ntx; i++) sb.push_back(txs[t.tx0 + i]);
      @(negedge clk);
      start_a[t.k]    = 1'b1;
      spi_done_a[t.k] = t.dn0;
      due = -1;
      fin = 0;
      for (int c = 1; c < 200 && fin == 0; c++) begin
         @(negedge clk);
         start_a[t.k]    = c == t.sp_start;
         spi_done_a[t.k] = c == due || c == t.sp_done;
         rdata_a[t.k]    = c == due ? cur.rdata : 8'($urandom);
         if (c == 1) begin
            chk($sformatf("busy_c1_k%0d", t.k), busy_a[t.k], 1);
            chk($sformatf("done_c1_k%0d", t.k), done_a[t.k], 0);
            chk($sformatf("err_c1_k%0d", t.k), error_a[t.k], 0);
         end
         if (req_a[t.k]) begin
            if (sb.size() == 0) chk($sformatf("extra_req_k%0d_c%0d", t.k, c), 1, 0);
            else begin
               cur = sb.pop_front();
               chk($sformatf("req_cyc_k%0d", t.k), c, cur.cyc);
               chk($sformatf("req_rw_k%0d_c%0d", t.k, c), rw_a[t.k], cur.rw);
               chk($sformatf("req_addr_k%0d_c%0d", t.k, c), addr_a[t.k], cur.addr);
               chk($sformatf("req_wdata_k%0d_c%0d", t.k, c), wdata_a[t.k], cur.wdata);
               due = c + LAT;
            end
         end
         if (done_a[t.k] || error_a[t.k]) fin = c;
      end
      spi_done_a[t.k] = 1'b0;
      start_a[t.k]    = 1'b0;
      chk($sformatf("timeout_k%0d", t.k), fin != 0, 1);
      if (fin != 0) begin
         chk($sformatf("end_cyc_k%0d", t.k), fin, t.e_end);
         chk($sformatf("done_k%0d", t.k), done_a[t.k], t.e_done);
         chk($sformatf("error_k%0d", t.k), error_a[t.k], t.e_err);
         chk($sformatf("busy_end_k%0d", t.k), busy_a[t.k], 0);
         if (t.e_err) chk($sformatf("err_step_k%0d", t.k), step_a[t.k], t.e_step);
      end
      chk($sformatf("tx_left_k%0d", t.k), sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      txs[0]  = '{1'b0, 10'h3F5, 8'h01, 8'h00, 3};
      txs[1]  = '{1'b1, 10'h247, 8'h02, 8'h00, 3};
      txs[2]  = '{1'b1, 10'h247, 8'h02, 8'h03, 19};
      txs[3]  = '{1'b1, 10'h247, 8'h02, 8'h00, 3};
      txs[4]  = '{1'b1, 10'h247, 8'h02, 8'h00, 19};
      txs[5]  = '{1'b1, 10'h247, 8'h02, 8'h00, 35};
      txs[6]  = '{1'b0, 10'h010, 8'hAA, 8'h00, 3};
      txs[7]  = '{1'b0, 10'h011, 8'hBB, 8'h00, 13};
      txs[8]  = '{1'b0, 10'h100, 8'h55, 8'h00, 3};
      txs[9]  = '{1'b1, 10'h120, 8'h80, 8'h80, 16};
      txs[10] = '{1'b1, 10'h120, 8'h80, 8'h7F, 32};
      tcs[0]  = '{0, 0, 1, 1'b0, -1, -1, 1'b1, 1'b0, 12'd0, 13};
      tcs[1]  = '{1, 0, 0, 1'b0,  5,  6, 1'b1, 1'b0, 12'd0, 17};
      tcs[2]  = '{2, 1, 2, 1'b0, -1, -1, 1'b1, 1'b0, 12'd0, 29};
      tcs[3]  = '{2, 3, 3, 1'b0, -1, -1, 1'b0, 1'b1, 12'd0, 43};
      tcs[4]  = '{3, 6, 2, 1'b0, -1, -1, 1'b0, 1'b1, 12'd2, 23};
      tcs[5]  = '{3, 6, 2, 1'b1, -1, -1, 1'b0, 1'b1, 12'd2, 23};
      tcs[6]  = '{4, 8, 3, 1'b0, -1, -1, 1'b0, 1'b1, 12'd3, 42};
      tcs[7]  = '{0, 0, 1, 1'b1, -1, -1, 1'b1, 1'b0, 12'd0, 13};
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         start_a[k]    = 1'b0;
         spi_done_a[k] = 1'b0;
         rdata_a[k]    = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < NI; k++) chk_reset(k, "init");
      for (int i = 0; i < 8; i++) run(tcs[i]);
      // Abort a write mid-transaction, then rerun the same profile from scratch.
      @(negedge clk);
      start_a[0] = 1'b1;
      @(negedge clk);
      start_a[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_before_rst", busy_a[0], 1);
      chk("addr_before_rst", addr_a[0], 10'h3F5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset(0, "abort");
      run(tcs[0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
